// File: rtl/linreg_engine.sv
// linreg_engine: streaming least-squares line fit, y = B0 + B1*x.
// Per-sample sums feed one shared restoring divider that yields B1, then B0.
module linreg_engine #(
   parameter int DATA_W = 20,
   parameter int FRAC_W = 10,
   parameter int N_MAX  = 150,
   parameter int OUT_W  = 48,
   localparam int CNT_W = $clog2(N_MAX + 1)
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     start,
   input  logic [CNT_W-1:0]         n_samples,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic signed [DATA_W-1:0] x,
   input  logic signed [DATA_W-1:0] y,
   output logic                     busy,
   output logic                     done,
   output logic                     div0,
   output logic                     ovf,
   output logic signed [OUT_W-1:0]  B1_out,
   output logic signed [OUT_W-1:0]  B0_out
);

   localparam int SW    = DATA_W + CNT_W;
   localparam int PW    = 2 * DATA_W + CNT_W;
   localparam int NW    = 2 * DATA_W + 2 * CNT_W + 1;
   localparam int DIV_W = NW + FRAC_W + 1;
   localparam int BW    = DIV_W + 1;
   localparam int TW    = OUT_W + SW + 1;
   localparam int DCW   = $clog2(DIV_W + 1);

   typedef enum logic [2:0] {
      IDLE, ACCUM, CALC, DIV_B1, PREP_B0, DIV_B0, DONE
   } state_t;

   state_t state, nxt;

   logic [CNT_W-1:0]         n_reg, cnt, cnt_nx;
   logic signed [SW-1:0]     sx, sy;
   logic signed [PW-1:0]     sxy, sxx;
   logic [DIV_W-1:0]         dvd, quo;
   logic [NW-1:0]            dsr, rem, rem_n;
   logic                     qneg, dz, ov1;
   logic [DCW-1:0]           dcnt;
   logic signed [OUT_W-1:0]  b1;

   logic                     accept, div_last, ge;
   logic signed [2*DATA_W-1:0] pxy, pxx;
   logic signed [CNT_W:0]    n_s;
   logic signed [NW-1:0]     nsxy, sxsy, nsxx, sxsx, num_c, den_c;
   logic [NW-1:0]            abs_num, abs_den;
   logic [NW:0]              trial;
   logic signed [BW-1:0]     q_ext, q_sgn, q_fix;
   logic [BW-OUT_W:0]        hi;
   logic                     s_ovf;
   logic signed [OUT_W-1:0]  s_val;
   logic signed [TW-1:0]     bsx, t;
   logic [TW-1:0]            abs_t;

   assign in_ready = (state == ACCUM);
   assign busy     = (state != IDLE);
   assign accept   = in_valid && in_ready;
   assign cnt_nx   = cnt + CNT_W'(1);
   assign div_last = (dcnt == DCW'(DIV_W - 1));

   assign pxy  = x * y;
   assign pxx  = x * x;
   assign n_s  = {1'b0, n_reg};
   assign nsxy = NW'(n_s) * NW'(sxy);
   assign sxsy = NW'(sx) * NW'(sy);
   assign nsxx = NW'(n_s) * NW'(sxx);
   assign sxsx = NW'(sx) * NW'(sx);
   assign num_c   = nsxy - sxsy;
   assign den_c   = nsxx - sxsx;
   assign abs_num = num_c[NW-1] ? -num_c : num_c;
   assign abs_den = den_c[NW-1] ? -den_c : den_c;

   // One quotient bit per cycle; remainder always stays below the divisor.
   assign trial = {rem, dvd[DIV_W-1]};
   assign ge    = (trial >= {1'b0, dsr});
   assign rem_n = ge ? NW'(trial - {1'b0, dsr}) : trial[NW-1:0];

   assign q_ext = {1'b0, quo};
   assign q_sgn = qneg ? -q_ext : q_ext;
   assign q_fix = (dz && state == PREP_B0) ? '0 : q_sgn;
   assign hi    = q_fix[BW-1:OUT_W-1];
   assign s_ovf = !((hi == '0) || (&hi));
   assign s_val = !s_ovf ? q_fix[OUT_W-1:0] :
                  q_fix[BW-1] ? {1'b1, {(OUT_W-1){1'b0}}} :
                                {1'b0, {(OUT_W-1){1'b1}}};

   assign bsx   = TW'(s_val) * TW'(sx);
   assign t     = TW'(sy) - (bsx >>> FRAC_W);
   assign abs_t = t[TW-1] ? -t : t;

   always_comb begin
      nxt = state;
      unique case (state)
         IDLE:    if (start && n_samples != '0) nxt = ACCUM;
         ACCUM:   if (accept && cnt_nx == n_reg) nxt = CALC;
         CALC:    nxt = DIV_B1;
         DIV_B1:  if (div_last) nxt = PREP_B0;
         PREP_B0: nxt = DIV_B0;
         DIV_B0:  if (div_last) nxt = DONE;
         DONE:    nxt = IDLE;
         default: nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= nxt;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         n_reg <= '0; cnt <= '0;
         sx <= '0; sy <= '0; sxy <= '0; sxx <= '0;
         dvd <= '0; quo <= '0; dsr <= '0; rem <= '0;
         qneg <= 1'b0; dz <= 1'b0; ov1 <= 1'b0;
         dcnt <= '0; b1 <= '0;
         done <= 1'b0; div0 <= 1'b0; ovf <= 1'b0;
         B1_out <= '0; B0_out <= '0;
      end else begin
         done <= 1'b0;
         unique case (state)
            IDLE: if (start && n_samples != '0) begin
               n_reg <= (n_samples > CNT_W'(N_MAX)) ?
                        CNT_W'(N_MAX) : n_samples;
               cnt <= '0;
               sx <= '0; sy <= '0; sxy <= '0; sxx <= '0;
               div0 <= 1'b0; ovf <= 1'b0;
               dz <= 1'b0; ov1 <= 1'b0;
            end
            ACCUM: if (accept) begin
               sx  <= sx + SW'(x);
               sy  <= sy + SW'(y);
               sxy <= sxy + PW'(pxy);
               sxx <= sxx + PW'(pxx);
               cnt <= cnt_nx;
            end
            CALC: begin
               dz   <= (den_c == '0);
               qneg <= num_c[NW-1] ^ den_c[NW-1];
               dvd  <= DIV_W'({abs_num, {FRAC_W{1'b0}}});
               dsr  <= abs_den;
               rem  <= '0;
               dcnt <= '0;
            end
            DIV_B1, DIV_B0: begin
               dvd  <= dvd << 1;
               rem  <= rem_n;
               quo  <= {quo[DIV_W-2:0], ge};
               dcnt <= dcnt + DCW'(1);
            end
            PREP_B0: begin
               b1   <= s_val;
               ov1  <= s_ovf;
               qneg <= t[TW-1];
               dvd  <= DIV_W'(abs_t);
               dsr  <= NW'(n_reg);
               rem  <= '0;
               dcnt <= '0;
            end
            DONE: begin
               B1_out <= b1;
               B0_out <= s_val;
               div0   <= dz;
               ovf    <= ov1 | s_ovf;
               done   <= 1'b1;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_linreg_engine.sv
// tb_linreg_engine: random and directed runs against a wide-integer model.
// Two instances (OUT_W=48 and OUT_W=16) share stimulus; one monitor checks both.
module tb_linreg_engine;

   localparam int DATA_W = 20;
   localparam int N_MAX  = 150;
   localparam int CNT_W  = 8;
   localparam int DIV_W  = 68;
   localparam int LAT    = 2 * DIV_W + 3;

   logic clk = 1'b0;
   logic rst, start, in_valid;
   logic [CNT_W-1:0] n_samples;
   logic signed [DATA_W-1:0] x, y;

   logic in_ready, busy48, done48, div0_48, ovf48;
   logic signed [47:0] b1_48, b0_48;
   logic in_ready16, busy16, done16, div0_16, ovf16;
   logic signed [15:0] b1_16, b0_16;

   always #5 clk = ~clk;

   linreg_engine dut48 (
      .clk(clk), .rst(rst), .start(start), .n_samples(n_samples),
      .in_valid(in_valid), .in_ready(in_ready), .x(x), .y(y),
      .busy(busy48), .done(done48), .div0(div0_48), .ovf(ovf48),
      .B1_out(b1_48), .B0_out(b0_48));

   linreg_engine #(.OUT_W(16)) dut16 (
      .clk(clk), .rst(rst), .start(start), .n_samples(n_samples),
      .in_valid(in_valid), .in_ready(in_ready16), .x(x), .y(y),
      .busy(busy16), .done(done16), .div0(div0_16), .ovf(ovf16),
      .B1_out(b1_16), .B0_out(b0_16));

   typedef struct {
      longint b1a, b0a, b1b, b0b, cyc;
      bit d0, oa, ob;
   } exp_t;

   exp_t sbq[$];
   int xs[N_MAX];
   int ys[N_MAX];
   int cyc = 0;
   int checks = 0;
   int errors = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(string nm, longint act, longint exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   function automatic longint satv(input logic signed [127:0] v,
                                   input int w, output bit o);
      logic signed [127:0] mx, mn;
      mx = (128'sd1 <<< (w - 1)) - 128'sd1;
      mn = -mx - 128'sd1;
      o = 1'b0;
      if (v > mx) begin o = 1'b1; return longint'(mx); end
      if (v < mn) begin o = 1'b1; return longint'(mn); end
      return longint'(v);
   endfunction

   // Closed-form least squares on exact integers, fractional scale 2^10.
   function automatic exp_t model(input int n);
      exp_t e;
      logic signed [127:0] nn, sx, sy, sxy, sxx, xi, yi;
      logic signed [127:0] num, den, b1f, b1s, t, b0f;
      bit o1, o2;
      nn = n; sx = 0; sy = 0; sxy = 0; sxx = 0;
      for (int i = 0; i < n; i++) begin
         xi = xs[i]; yi = ys[i];
         sx += xi; sy += yi; sxy += xi * yi; sxx += xi * xi;
      end
      num = nn * sxy - sx * sy;
      den = nn * sxx - sx * sx;
      e.d0 = (den == 0);
      b1f = e.d0 ? 128'sd0 : (num * 128'sd1024) / den;
      e.b1a = satv(b1f, 48, o1);
      b1s = e.b1a;
      t = sy - ((b1s * sx) >>> 10);
      b0f = t / nn;
      e.b0a = satv(b0f, 48, o2);
      e.oa = o1 | o2;
      e.b1b = satv(b1f, 16, o1);
      b1s = e.b1b;
      t = sy - ((b1s * sx) >>> 10);
      b0f = t / nn;
      e.b0b = satv(b0f, 16, o2);
      e.ob = o1 | o2;
      e.cyc = 0;
      return e;
   endfunction

   always @(negedge clk) begin
      if (done48 || done16) begin
         if (sbq.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_done: got done=1 expected none");
         end else begin
            exp_t e;
            e = sbq.pop_front();
            chk("latency", cyc, e.cyc);
            chk("done16_sync", done16, done48);
            chk("B1_48", b1_48, e.b1a);
            chk("B0_48", b0_48, e.b0a);
            chk("div0_48", div0_48, e.d0);
            chk("ovf_48", ovf48, e.oa);
            chk("B1_16", b1_16, e.b1b);
            chk("B0_16", b0_16, e.b0b);
            chk("div0_16", div0_16, e.d0);
            chk("ovf_16", ovf16, e.ob);
         end
      end
   end

   task automatic fill_rand(input int n);
      for (int i = 0; i < n; i++) begin
         xs[i] = int'($signed(DATA_W'($urandom)));
         ys[i] = int'($signed(DATA_W'($urandom)));
      end
   endtask

   task automatic run(input int nreq, input int nacc,
                      input bit gaps, input bit poke);
      int got, budget;
      bit acc;
      exp_t e;
      got = 0; budget = 0;
      @(posedge clk); #1;
      start = 1'b1; n_samples = CNT_W'(nreq);
      @(posedge clk); #1;
      start = 1'b0;
      while (got < nacc && budget < 4000) begin
         in_valid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
         x = DATA_W'(xs[got]);
         y = DATA_W'(ys[got]);
         start = poke && (got == nacc / 2);
         @(negedge clk);
         acc = in_valid && in_ready;
         @(posedge clk); #1;
         if (acc) got++;
         budget++;
      end
      start = 1'b0;
      chk("accepts", got, nacc);
      if (got == nacc) begin
         e = model(nacc);
         e.cyc = cyc + LAT;
         sbq.push_back(e);
      end
      in_valid = 1'b1;
      repeat (3) begin
         @(negedge clk);
         chk("extra_ready48", in_ready, 0);
         chk("extra_ready16", in_ready16, 0);
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
      if (poke) begin
         start = 1'b1;
         @(posedge clk); #1;
         start = 1'b0;
      end
   endtask

   task automatic wait_done();
      int b;
      b = 0;
      while ((sbq.size() != 0 || busy48 || busy16) && b < 500) begin
         @(posedge clk);
         b++;
      end
      chk("run_completes", b < 500, 1);
      @(posedge clk); #1;
   endtask

   task automatic check_cleared(input string tag);
      chk({tag, "_B1"}, b1_48, 0);
      chk({tag, "_B0"}, b0_48, 0);
      chk({tag, "_busy"}, busy48, 0);
      chk({tag, "_done"}, done48, 0);
      chk({tag, "_ready"}, in_ready, 0);
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; in_valid = 1'b0;
      n_samples = '0; x = '0; y = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_cleared("reset");
      chk("reset_div0", div0_48, 0);
      chk("reset_ovf", ovf48, 0);
      rst = 1'b0;

      // y = 2x + 1 over x = 1..4
      for (int i = 0; i < 4; i++) begin
         xs[i] = (i + 1) * 1024;
         ys[i] = 2 * xs[i] + 1024;
      end
      run(4, 4, 1'b0, 1'b0);
      wait_done();

      for (int i = 0; i < 3; i++) begin
         xs[i] = (i + 1) * 1024; ys[i] = 3072;
      end
      run(3, 3, 1'b0, 1'b0);
      wait_done();
      xs[0] = -1; xs[1] = 0; xs[2] = 1;
      ys[0] = 1;  ys[1] = 0; ys[2] = -1;
      run(3, 3, 1'b1, 1'b0);
      wait_done();

      // vertical data: zero denominator
      for (int i = 0; i < 5; i++) begin
         xs[i] = 2048; ys[i] = (i + 1) * 1024;
      end
      run(5, 5, 1'b0, 1'b0);
      wait_done();

      in_valid = 1'b1;
      @(negedge clk);
      chk("idle_ready", in_ready, 0);
      @(posedge clk); #1;
      in_valid = 1'b0;
      fill_rand(150);
      run(150, 150, 1'b1, 1'b1);
      wait_done();

      @(posedge clk); #1;
      start = 1'b1; n_samples = '0;
      @(posedge clk); #1;
      start = 1'b0;
      @(negedge clk);
      chk("n0_busy", busy48, 0);
      fill_rand(150);
      run(200, 150, 1'b1, 1'b0);
      wait_done();

      // steep slope: saturates the narrow instance
      xs[0] = 0; ys[0] = -524288;
      xs[1] = 1; ys[1] = 524287;
      run(2, 2, 1'b0, 1'b0);
      wait_done();

      for (int r = 0; r < 3; r++) begin
         int n;
         n = $urandom_range(1, N_MAX);
         fill_rand(n);
         run(n, n, 1'b1, 1'b0);
         wait_done();
      end

      // abort in ACCUM
      fill_rand(10);
      @(posedge clk); #1;
      start = 1'b1; n_samples = 8'd10;
      @(posedge clk); #1;
      start = 1'b0;
      for (int i = 0; i < 5; i++) begin
         in_valid = 1'b1; x = DATA_W'(xs[i]); y = DATA_W'(ys[i]);
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
      #1 rst = 1'b1;
      #1 check_cleared("rst_accum");
      @(negedge clk); rst = 1'b0;

      // abort in DIV_B1
      fill_rand(20);
      run(20, 20, 1'b0, 1'b0);
      repeat (10) @(posedge clk);
      #2 rst = 1'b1;
      sbq.delete();
      #1 check_cleared("rst_div");
      @(negedge clk); rst = 1'b0;
      repeat (200) @(posedge clk);

      fill_rand(37);
      run(37, 37, 1'b1, 1'b0);
      wait_done();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/linreg_engine.md
Name: linreg_engine

Overview:
Self-sequenced, parametrised least-squares linear-regression engine. Accepts a stream of signed fixed-point (x, y) samples over a valid/ready handshake. Accumulates Σx, Σy, Σxy and Σxx, then computes B1 = (N·Σxy − Σx·Σy)/(N·Σxx − Σx²) and B0 = (Σy − B1·Σx)/N with one shared sequential divider. Successor to the fixed 150-sample, externally-controlled coefficient datapath: the sample count is set at run time and the controller FSM is internal.

Parameters:
DATA_W, 20, width of x and y (signed two's complement)
FRAC_W, 10, fractional bits of x, y, B0 and B1
N_MAX, 150, maximum samples per run; CNT_W = clog2(N_MAX+1)
OUT_W, 48, width of B0_out and B1_out (signed, FRAC_W fractional bits)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous active-high reset
start  in  1  single-cycle run request, honoured only in IDLE
n_samples  in  CNT_W  sample count N, latched on an accepted start
in_valid  in  1  sample valid
in_ready  out  1  engine accepts a sample (high only in ACCUM)
x  in  DATA_W  sample x
y  in  DATA_W  sample y
busy  out  1  high in every state except IDLE
done  out  1  one-cycle pulse when B0_out/B1_out are updated
div0  out  1  sticky per run: denominator was zero
ovf  out  1  sticky per run: B0 or B1 saturated
B1_out  out  OUT_W  slope, held until the next done
B0_out  out  OUT_W  intercept, held until the next done

Behaviour:
- Reset (async, any state): FSM goes to IDLE. Accumulators, sample counter, B0_out, B1_out, done, div0, ovf and busy are all 0. Reset mid-run aborts the run with no done.
- States: IDLE → ACCUM → CALC → DIV_B1 → PREP_B0 → DIV_B0 → DONE → IDLE.
- IDLE: start with n_samples=0 is ignored. start with n_samples>N_MAX latches N=N_MAX. An accepted start clears the accumulators, counter, div0 and ovf. B0_out/B1_out keep their old values.
- ACCUM: in_ready=1. A sample is accepted on a cycle with in_valid && in_ready. Gaps are allowed and in_valid is ignored when in_ready=0. On each accepted sample:
  - Sx += x, Sy += y, Sxy += x·y, Sxx += x·x (full-precision signed).
  - Widths: Sx/Sy use DATA_W+CNT_W bits; Sxy/Sxx use 2·DATA_W+CNT_W bits.
  - The accept that brings the count to N moves the FSM to CALC on the next edge.
- CALC (1 cycle): register num = N·Sxy − Sx·Sy and den = N·Sxx − Sx·Sx. Both are scale 2^(2·FRAC_W), width NW = 2·DATA_W+2·CNT_W+1.
- DIV_B1 (exactly DIV_W = NW+FRAC_W+1 cycles): restoring divide of |num|<<FRAC_W by |den|, one quotient bit per cycle.
  - Sign is restored afterwards; the result truncates toward zero.
  - den=0: set div0 and force B1=0 (the divider still runs the full DIV_W cycles, keeping latency constant).
- PREP_B0 (1 cycle): t = Sy − ((B1·Sx) >>> FRAC_W), arithmetic shift.
- DIV_B0 (exactly DIV_W cycles): B0 = t / N, signed, truncating toward zero, on the same shared divider.
- Saturation: if B1 or B0 falls outside the signed OUT_W range, clamp to max/min and set ovf.
- DONE (1 cycle): B1_out and B0_out are registered, done=1; next state IDLE. Results and flags are visible on the same edge that raises done.
- Latency from the edge accepting the last sample to done high: 2·DIV_W+3 cycles.
- start while busy is ignored. start arriving in the same cycle that DONE → IDLE is also ignored; start is honoured from the following cycle.
- No internal wrap: with N ≤ N_MAX the accumulator widths cannot overflow.

Test Plan:
1. N=4, x={1,2,3,4}, y=2x+1 (raw x=1024…4096, y=3072…9216) → B1_out=2048, B0_out=1024, div0=0, ovf=0, done one cycle exactly 2·DIV_W+3 after last accept.
2. N=3, x={1,2,3}, y=3.0 each → B1_out=0, B0_out=3072; then N=3, x={−1,0,1}, y={1,0,−1} (raw) → B1_out=−1024, B0_out=0.
3. N=5, x=2.0 constant, y={1,2,3,4,5} → div0=1, B1_out=0, B0_out=3072 (mean y).
4. Handshake: in_valid toggled randomly across 150 samples, start pulsed while busy, in_valid asserted in IDLE → only 150 samples accepted, extra start ignored, result equals golden model.
5. Reset asserted asynchronously mid-ACCUM and mid-DIV_B1 → outputs zero immediately, no done; a fresh run afterwards produces correct results.
6. n_samples=0 start ignored (busy stays 0); n_samples=200 → run terminates after 150 accepts; large-slope data (x≈0 spread 1 LSB, y full-scale) with OUT_W=16 → saturated B1_out = 32767 and ovf=1.
